onoff_cmd_driver: RTL and testbench
===================================

// Module: onoff_cmd_driver
// PURPOSE
// - Command-side driver for a two-state ON/OFF Moore controller (A = turn-on input, B = turn-off input, out = state).
// - Accepts ON/OFF requests on a valid/ready interface and pulses A or B.
// - Confirms the transition by watching the controller's out feedback.
// - Reports completion (done) or a missed transition (err, timeout).
// PARAMETERS
// - PULSE_CYCLES    1   cycles A or B is held high per command (>=1)
// - TIMEOUT_CYCLES  8   WAIT-state cycles allowed for feedback to match before err (>=1)
// - CNT_W           4   counter width; must hold max(PULSE_CYCLES, TIMEOUT_CYCLES)
// PORTS
// - clk        in   1  clock, rising edge
// - reset      in   1  asynchronous, active-high
// - req_valid  in   1  request present
// - req_on     in   1  requested target: 1 = ON, 0 = OFF
// - req_ready  out  1  driver can accept; combinational, equals (state == IDLE)
// - fsm_out    in   1  feedback from the controller's out
// - a_on       out  1  registered; drives controller A
// - b_off      out  1  registered; drives controller B
// - busy       out  1  registered; 1 in DRIVE or WAIT
// - done       out  1  registered one-cycle pulse: target state confirmed
// - err        out  1  registered one-cycle pulse: timeout, target not reached
// BEHAVIOUR
// - Reset (async): state IDLE; a_on = b_off = busy = done = err = 0; counter = 0; req_ready = 1.
// - Reset mid-command aborts immediately: A/B drop at once; no done or err is issued.
// - Handshake: accept on the rising edge where req_valid & req_ready. The target is latched in tgt.
//   - req_on and req_valid are ignored while busy.
// - States: IDLE, DRIVE, WAIT.
//   - IDLE, accept, fsm_out == req_on (no-op): stay IDLE; done = 1 for the next cycle; no A/B pulse.
//   - IDLE, accept, fsm_out != req_on: go to DRIVE. Set a_on = tgt, b_off = ~tgt, busy = 1, counter = PULSE_CYCLES-1.
//   - DRIVE: hold the pulse. At counter == 0, clear a_on/b_off, go to WAIT, counter = TIMEOUT_CYCLES-1. Otherwise decrement.
//     - fsm_out is not checked in DRIVE.
//   - WAIT, fsm_out == tgt: go to IDLE, done = 1 for one cycle, busy = 0.
//   - WAIT, mismatch with counter == 0: go to IDLE, err = 1 for one cycle, busy = 0. Otherwise decrement.
//   - Match has priority over timeout on the same edge.
// - a_on and b_off are never both 1; both are 0 outside DRIVE.
// - Latency (controller samples A/B one edge later):
//   - done is high on the (PULSE_CYCLES+1)th edge after the accept edge, for one cycle.
//   - Defaults: done is high the 2nd cycle after accept.
//   - No-op: done is high the 1st cycle after accept.
// - Back-to-back: req_ready = 1 during the done/err cycle, so a new request may be accepted on that edge.
// - done and err are mutually exclusive and never asserted with busy from the same command.
// STRUCTURE
// - Package onoff_pkg: state localparams IDLE = 2'd0, DRIVE = 2'd1, WAIT = 2'd2; level constants OFF = 1'b0, ON = 1'b1.
// - One sub-module: onoff_cycle_counter (CNT_W-bit loadable down-counter with load, dec and zero flag).
//   - Shared by the DRIVE and WAIT phases.
// - Checks: elaboration-time check on the PULSE_CYCLES, TIMEOUT_CYCLES and CNT_W constraints.
// TESTING (defaults; bench includes a two-state model: A sets ON, B clears to OFF, async reset to OFF)
// - Reset, then req_on = 1 -> a_on high 1 cycle, fsm_out = 1, done on the 2nd cycle after accept, err = 0.
// - Model ON, req_on = 1 -> no A/B pulse; done on the 1st cycle after accept; busy stays 0.
// - ON, then req_on = 0 -> b_off high 1 cycle, fsm_out = 0, done; a_on stays 0 throughout.
// - Model stuck (ignores A), req_on = 1 -> err after 1 DRIVE + 8 WAIT cycles; no done.
// - reset asserted during DRIVE -> a_on/b_off = 0 at once, no done/err; next request is accepted normally.
// - req_valid held high with alternating req_on, PULSE_CYCLES = 3 -> accepted only in IDLE.
//   - Each pulse is 3 cycles wide; A and B are never both high.

Source files
------------

// File: rtl/onoff_pkg.sv
// Shared constants for the ON/OFF command driver.
//   - Controller-driver FSM state encodings (legacy 2-bit localparams).
//   - Controller output levels.
package onoff_pkg;

    // Driver FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    // Controller output levels
    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

endpackage

// File: rtl/onoff_cycle_counter.sv
// Loadable down-counter shared by the pulse (DRIVE) and timeout (WAIT) phases.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-high; clears the count
//   load     in  load load_val (has priority over dec)
//   load_val in  value to load
//   dec      in  decrement by one (saturates at zero)
//   count    out current count (registered)
//   zero     out count == 0
module onoff_cycle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Count register: load wins over decrement; never wraps below zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    // Zero flag used by the FSM to end a phase
    assign zero = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/onoff_cmd_driver.sv
// Command-side driver for a two-state ON/OFF Moore controller.
// Accepts ON/OFF requests (valid/ready), pulses A (a_on) or B (b_off),
// then watches the controller feedback (fsm_out) to confirm the move.
// Ports:
//   clk, reset      clock (rising) / asynchronous active-high reset
//   req_valid       request present
//   req_on          requested target (1 = ON, 0 = OFF)
//   req_ready       combinational, high only in IDLE
//   fsm_out         controller output feedback
//   a_on, b_off     registered pulses to controller A / B
//   busy            registered, high in DRIVE or WAIT
//   done, err       registered one-cycle completion / timeout pulses
module onoff_cmd_driver
    import onoff_pkg::*;
#(
    parameter int PULSE_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_on,
    output logic req_ready,
    input  logic fsm_out,
    output logic a_on,
    output logic b_off,
    output logic busy,
    output logic done,
    output logic err
);

    // The counter is loaded with (N-1), so N itself must fit in CNT_W bits.
    generate
        if (PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
            PULSE_CYCLES > (2**CNT_W) - 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_params
            $error("onoff_cmd_driver: PULSE_CYCLES/TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             tgt;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;

    // Counter control: load on phase entry, decrement while a phase is running
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = {CNT_W{1'b0}};
        case (state)
            IDLE: begin
                if (accept && (fsm_out != req_on)) begin
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LOAD;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = TIMEOUT_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WAIT: begin
                if (fsm_out != tgt) begin
                    cnt_dec = 1'b1;
                end else begin
                    cnt_dec = 1'b0;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    onoff_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // Main FSM and registered outputs; done/err default low so they pulse once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tgt   <= OFF;
            a_on  <= 1'b0;
            b_off <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt <= req_on;
                        if (fsm_out == req_on) begin
                            // Already there: confirm without pulsing the controller
                            done <= 1'b1;
                        end else begin
                            state <= DRIVE;
                            a_on  <= req_on;
                            b_off <= ~req_on;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    // Feedback is ignored here: the controller has not sampled A/B yet
                    if (cnt_zero) begin
                        a_on  <= 1'b0;
                        b_off <= 1'b0;
                        state <= WAIT;
                    end else begin
                        state <= DRIVE;
                    end
                end
                WAIT: begin
                    // A match wins over a timeout on the same edge
                    if (fsm_out == tgt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt_zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                    a_on  <= 1'b0;
                    b_off <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onoff_cmd_driver.sv
// Self-checking bench for onoff_cmd_driver: dut0 uses default parameters,
// dut1 uses PULSE_CYCLES = 3. Each drives a behavioural two-state controller.
module tb_onoff_cmd_driver;

    typedef struct packed {
        logic is_err;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // dut0 (defaults)
    logic req_valid0 = 1'b0, req_on0 = 1'b0, stuck0 = 1'b0;
    logic req_ready0, a_on0, b_off0, busy0, done0, err0, m_out0;
    // dut1 (PULSE_CYCLES = 3)
    logic req_valid1 = 1'b0, req_on1 = 1'b0;
    logic req_ready1, a_on1, b_off1, busy1, done1, err1, m_out1;

    int total = 0;
    int passed = 0;
    int both0 = 0;
    int both1 = 0;
    exp_t sb0[$];
    int   sb1[$];

    always #5 clk = ~clk;

    onoff_cmd_driver u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_on(req_on0),
        .req_ready(req_ready0), .fsm_out(m_out0), .a_on(a_on0), .b_off(b_off0),
        .busy(busy0), .done(done0), .err(err0)
    );

    onoff_cmd_driver #(.PULSE_CYCLES(3), .TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_on(req_on1),
        .req_ready(req_ready1), .fsm_out(m_out1), .a_on(a_on1), .b_off(b_off1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // Controller models: A sets ON, B clears to OFF, async reset to OFF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) m_out0 <= 1'b0;
        else if (!stuck0 && a_on0) m_out0 <= 1'b1;
        else if (!stuck0 && b_off0) m_out0 <= 1'b0;
        else m_out0 <= m_out0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) m_out1 <= 1'b0;
        else if (a_on1) m_out1 <= 1'b1;
        else if (b_off1) m_out1 <= 1'b0;
        else m_out1 <= m_out1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: A/B overlap on both DUTs and pulse width on dut1
    initial begin
        int run_a = 0;
        int run_b = 0;
        forever begin
            @(negedge clk);
            if (a_on0 && b_off0) both0++;
            if (a_on1 && b_off1) both1++;
            if (a_on1) run_a++;
            else if (run_a != 0) begin
                check("pulse3 A width", run_a, 3);
                run_a = 0;
            end
            if (b_off1) run_b++;
            else if (run_b != 0) begin
                check("pulse3 B width", run_b, 3);
                run_b = 0;
            end
        end
    end

    // Present a request to dut0 for one accept edge; expectation from the model
    task automatic issue0(input logic on, input bit push);
        exp_t e;
        e.is_err = stuck0 && (m_out0 != on);
        e.lat    = (m_out0 == on) ? 0 : (e.is_err ? 9 : 2);
        if (push) sb0.push_back(e);
        req_valid0 = 1'b1;
        req_on0    = on;
        tick();
        req_valid0 = 1'b0;
    endtask

    // Called right after the accept edge; waits (bounded) for done/err and scores it
    task automatic wait_result0(input string tag, output int a_cnt, output int b_cnt);
        int lat = 0;
        bit got = 0;
        exp_t e;
        a_cnt = 0;
        b_cnt = 0;
        while (!got && lat <= 20) begin
            if (a_on0) a_cnt++;
            if (b_off0) b_cnt++;
            if (done0 || err0) begin
                got = 1;
                if (sb0.size() == 0) begin
                    check({tag, " unexpected result"}, 32'd1, 32'd0);
                end else begin
                    e = sb0.pop_front();
                    check({tag, " done"}, {31'd0, done0}, {31'd0, ~e.is_err});
                    check({tag, " err"}, {31'd0, err0}, {31'd0, e.is_err});
                    check({tag, " latency"}, lat, e.lat);
                    check({tag, " busy at end"}, {31'd0, busy0}, 32'd0);
                    check({tag, " ready at end"}, {31'd0, req_ready0}, 32'd1);
                end
            end else begin
                tick();
                lat++;
            end
        end
        if (!got) check({tag, " no result within bound"}, 32'd0, 32'd1);
    endtask

    initial begin
        int ac, bc;
        // Reset state
        #2;
        check("reset a_on", {31'd0, a_on0}, 32'd0);
        check("reset b_off", {31'd0, b_off0}, 32'd0);
        check("reset busy", {31'd0, busy0}, 32'd0);
        check("reset done/err", {30'd0, done0, err0}, 32'd0);
        check("reset ready", {31'd0, req_ready0}, 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // OFF -> ON
        issue0(1'b1, 1'b1);
        check("on busy", {31'd0, busy0}, 32'd1);
        check("on ready low", {31'd0, req_ready0}, 32'd0);
        wait_result0("on", ac, bc);
        check("on A width", ac, 1);
        check("on B width", bc, 0);
        check("on model", {31'd0, m_out0}, 32'd1);
        tick();

        // ON -> ON no-op
        issue0(1'b1, 1'b1);
        check("noop busy", {31'd0, busy0}, 32'd0);
        wait_result0("noop", ac, bc);
        check("noop A", ac, 0);
        check("noop B", bc, 0);
        tick();

        // ON -> OFF
        issue0(1'b0, 1'b1);
        wait_result0("off", ac, bc);
        check("off A", ac, 0);
        check("off B width", bc, 1);
        check("off model", {31'd0, m_out0}, 32'd0);
        tick();

        // Stuck controller -> timeout
        stuck0 = 1'b1;
        issue0(1'b1, 1'b1);
        wait_result0("timeout", ac, bc);
        check("timeout A width", ac, 1);
        stuck0 = 1'b0;
        tick();
        check("timeout err one cycle", {31'd0, err0}, 32'd0);

        // Reset during DRIVE aborts at once
        issue0(1'b1, 1'b0);
        check("abort a_on before", {31'd0, a_on0}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort a_on", {31'd0, a_on0}, 32'd0);
        check("abort b_off", {31'd0, b_off0}, 32'd0);
        check("abort busy", {31'd0, busy0}, 32'd0);
        tick();
        check("abort done/err", {30'd0, done0, err0}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort done/err after", {30'd0, done0, err0}, 32'd0);

        // Normal after abort, then back-to-back OFF in the done cycle
        issue0(1'b1, 1'b1);
        wait_result0("post-abort on", ac, bc);
        issue0(1'b0, 1'b1);
        wait_result0("back-to-back off", ac, bc);
        check("b2b B width", bc, 1);
        check("dut0 queue empty", sb0.size(), 0);

        // dut1: valid held high, req_on alternating; accepts only in IDLE
        for (int i = 0; i < 45; i++) begin
            bit acc;
            bit noop;
            req_valid1 = (i < 30);
            req_on1    = i[0];
            acc  = req_valid1 && req_ready1;
            noop = (m_out1 == req_on1);
            check("pulse3 ready vs busy", {31'd0, req_ready1}, {31'd0, ~busy1});
            tick();
            if (acc) sb1.push_back(noop ? i : i + 4);
            if (done1 || err1) begin
                check("pulse3 err", {31'd0, err1}, 32'd0);
                if (sb1.size() == 0) check("pulse3 unexpected done", 32'd1, 32'd0);
                else check("pulse3 done edge", i, sb1.pop_front());
            end
        end
        check("dut1 queue empty", sb1.size(), 0);
        check("dut0 A/B overlap", both0, 0);
        check("dut1 A/B overlap", both1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
